regfile_scoreboard: RTL and testbench

- Parametrised multi-ported register file with an integrated pending-write scoreboard, replacing the fixed 8x8 register file in the datapath.
- Provides two asynchronous read ports with same-cycle write bypass and one synchronous write port, with optional hardwired zero register.
- Tracks registers that have an outstanding result (issue sets pending, writeback clears it) so decode can detect RAW/WAW hazards and stall.

---
 rtl/regfile_scoreboard_if.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/issue bundle for the register file scoreboard
//
// Purpose: groups the read ports, writeback port and issue/scoreboard signals.
// Ports (master = decode/datapath side, slave = register file):
//   a_address, b_address  read addresses          master -> slave
//   a_data, b_data        read data               slave  -> master
//   a_busy, b_busy        read register pending   slave  -> master
//   d_address, datain     writeback addr/data     master -> slave
//   write_en              writeback strobe        master -> slave
//   iss_en, iss_address   issue request/dest reg  master -> slave
//   iss_ok                issue acceptable        slave  -> master
//   pend_cnt              pending register count  slave  -> master
//   wb_err                sticky bad-writeback    slave  -> master
interface regfile_scoreboard_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] a_address;
  logic [ADDR_W-1:0] b_address;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              a_busy;
  logic              b_busy;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] datain;
  logic              write_en;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_address;
  logic              iss_ok;
  logic [ADDR_W:0]   pend_cnt;
  logic              wb_err;

  modport master (
    output a_address, b_address, d_address, datain, write_en, iss_en, iss_address,
    input  a_data, b_data, a_busy, b_busy, iss_ok, pend_cnt, wb_err
  );

  modport slave (
    input  a_address, b_address, d_address, datain, write_en, iss_en, iss_address,
    output a_data, b_data, a_busy, b_busy, iss_ok, pend_cnt, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with two read ports, one write port and pending-write scoreboard
//
// Purpose: 2**ADDR_W x DATA_W register file. Reads are combinational with
// optional same-cycle writeback bypass; each register carries a pending bit
// set on issue and cleared on writeback so decode can stall on RAW/WAW.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears data, pending bits, count, error)
//   bus  regfile_scoreboard_if.slave (read ports, writeback, issue, status)
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_nxt;
  logic              wb_err_q;
  logic              wb_hit;
  logic              iss_acc;
  logic              a_bypass;
  logic              b_bypass;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  always_comb begin
    // Writes to the hardwired zero register are dropped entirely.
    wb_hit = bus.write_en && !is_zero(bus.d_address);

    // A writeback to the same register this cycle frees its pending bit,
    // so the issue may proceed without waiting another cycle.
    bus.iss_ok = is_zero(bus.iss_address) || !pending[bus.iss_address] ||
                 (bus.write_en && (bus.d_address == bus.iss_address));
    iss_acc    = bus.iss_en && bus.iss_ok && !is_zero(bus.iss_address);

    a_bypass = (BYPASS != 0) && wb_hit && (bus.d_address == bus.a_address);
    b_bypass = (BYPASS != 0) && wb_hit && (bus.d_address == bus.b_address);

    if (is_zero(bus.a_address)) begin
      bus.a_data = '0;
      bus.a_busy = 1'b0;
    end else if (a_bypass) begin
      bus.a_data = bus.datain;
      bus.a_busy = iss_acc && (bus.iss_address == bus.a_address);
    end else begin
      bus.a_data = regs[bus.a_address];
      bus.a_busy = pending[bus.a_address];
    end

    if (is_zero(bus.b_address)) begin
      bus.b_data = '0;
      bus.b_busy = 1'b0;
    end else if (b_bypass) begin
      bus.b_data = bus.datain;
      bus.b_busy = iss_acc && (bus.iss_address == bus.b_address);
    end else begin
      bus.b_data = regs[bus.b_address];
      bus.b_busy = pending[bus.b_address];
    end
  end

  always_comb begin
    // Clear before set: a same-register issue and writeback leaves it pending.
    pending_nxt = pending;
    if (wb_hit) pending_nxt[bus.d_address] = 1'b0;
    if (iss_acc) pending_nxt[bus.iss_address] = 1'b1;

    pend_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_nxt = pend_cnt_nxt + {{ADDR_W{1'b0}}, pending_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending    <= '0;
      pend_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      if (wb_hit) regs[bus.d_address] <= bus.datain;
      pending    <= pending_nxt;
      pend_cnt_q <= pend_cnt_nxt;
      if (wb_hit && !pending[bus.d_address]) wb_err_q <= 1'b1;
    end
  end

  assign bus.pend_cnt = pend_cnt_q;
  assign bus.wb_err   = wb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for two regfile_scoreboard configurations
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: 8x8, zero register, bypass. Instance 1: 16x16, no zero register, no bypass.
  regfile_scoreboard_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

  regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic        rst, we, ie;
    logic [3:0]  a, b, d, ia;
    logic [15:0] din;
  } stim_t;

  typedef struct packed {
    logic [15:0] a_data, b_data;
    logic        a_busy, b_busy, iss_ok, wb_err;
    logic [4:0]  pend_cnt;
  } exp_t;

  typedef struct packed {
    exp_t e0, e1;
  } exp_pair_t;

  exp_pair_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference state: contents, pending flags and sticky error per instance.
  logic [15:0] m_reg  [2][16];
  bit          m_pend [2][16];
  bit          m_err  [2];

  function automatic int cfg_aw(int k);   return (k == 0) ? 3 : 4; endfunction
  function automatic int cfg_dw(int k);   return (k == 0) ? 8 : 16; endfunction
  function automatic bit cfg_zero(int k); return (k == 0); endfunction
  function automatic bit cfg_byp(int k);  return (k == 0); endfunction

  task automatic model_step(input int k, input stim_t s, output exp_t e);
    int amask = (1 << cfg_aw(k)) - 1;
    int a  = int'(s.a) & amask;
    int b  = int'(s.b) & amask;
    int d  = int'(s.d) & amask;
    int ia = int'(s.ia) & amask;
    logic [15:0] din = s.din & 16'((1 << cfg_dw(k)) - 1);
    bit zr = cfg_zero(k);
    bit wr_real = s.we && !(zr && d == 0);
    bit ok, acc;
    int cnt = 0;

    ok  = (zr && ia == 0) || !m_pend[k][ia] || (s.we && d == ia);
    acc = s.ie && ok && !(zr && ia == 0);

    if (zr && a == 0) begin
      e.a_data = '0; e.a_busy = 1'b0;
    end else if (cfg_byp(k) && wr_real && d == a) begin
      e.a_data = din; e.a_busy = acc && (ia == a);
    end else begin
      e.a_data = m_reg[k][a]; e.a_busy = m_pend[k][a];
    end
    if (zr && b == 0) begin
      e.b_data = '0; e.b_busy = 1'b0;
    end else if (cfg_byp(k) && wr_real && d == b) begin
      e.b_data = din; e.b_busy = acc && (ia == b);
    end else begin
      e.b_data = m_reg[k][b]; e.b_busy = m_pend[k][b];
    end
    for (int i = 0; i < 16; i++) cnt += int'(m_pend[k][i]);
    e.pend_cnt = 5'(cnt);
    e.iss_ok   = ok;
    e.wb_err   = m_err[k];

    if (s.rst) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[k][i]  = '0;
        m_pend[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
    end else begin
      if (wr_real) begin
        if (!m_pend[k][d]) m_err[k] = 1'b1;
        m_reg[k][d]  = din;
        m_pend[k][d] = 1'b0;
      end
      if (acc) m_pend[k][ia] = 1'b1;
    end
  endtask

  task automatic apply(input stim_t s);
    exp_pair_t p;
    @(posedge clk);
    #1;
    rst = s.rst;
    bus0.a_address = s.a[2:0];  bus0.b_address = s.b[2:0];
    bus0.d_address = s.d[2:0];  bus0.datain = s.din[7:0];
    bus0.write_en = s.we;       bus0.iss_en = s.ie;  bus0.iss_address = s.ia[2:0];
    bus1.a_address = s.a;       bus1.b_address = s.b;
    bus1.d_address = s.d;       bus1.datain = s.din;
    bus1.write_en = s.we;       bus1.iss_en = s.ie;  bus1.iss_address = s.ia;
    model_step(0, s, p.e0);
    model_step(1, s, p.e1);
    exp_q.push_back(p);
  endtask

  function automatic stim_t mk(bit r, bit we, int d, int din, bit ie, int ia, int a, int b);
    stim_t s;
    s.rst = r; s.we = we; s.ie = ie;
    s.d = 4'(d); s.din = 16'(din); s.ia = 4'(ia); s.a = 4'(a); s.b = 4'(b);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  exp_pair_t mon_p;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_p = exp_q.pop_front();
      check("a_data0",   bus0.a_data,   mon_p.e0.a_data);
      check("b_data0",   bus0.b_data,   mon_p.e0.b_data);
      check("a_busy0",   bus0.a_busy,   mon_p.e0.a_busy);
      check("b_busy0",   bus0.b_busy,   mon_p.e0.b_busy);
      check("iss_ok0",   bus0.iss_ok,   mon_p.e0.iss_ok);
      check("pend_cnt0", bus0.pend_cnt, mon_p.e0.pend_cnt);
      check("wb_err0",   bus0.wb_err,   mon_p.e0.wb_err);
      check("a_data1",   bus1.a_data,   mon_p.e1.a_data);
      check("b_data1",   bus1.b_data,   mon_p.e1.b_data);
      check("a_busy1",   bus1.a_busy,   mon_p.e1.a_busy);
      check("b_busy1",   bus1.b_busy,   mon_p.e1.b_busy);
      check("iss_ok1",   bus1.iss_ok,   mon_p.e1.iss_ok);
      check("pend_cnt1", bus1.pend_cnt, mon_p.e1.pend_cnt);
      check("wb_err1",   bus1.wb_err,   mon_p.e1.wb_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bus0.a_address = '0; bus0.b_address = '0; bus0.d_address = '0; bus0.datain = '0;
    bus0.write_en = 1'b0; bus0.iss_en = 1'b0; bus0.iss_address = '0;
    bus1.a_address = '0; bus1.b_address = '0; bus1.d_address = '0; bus1.datain = '0;
    bus1.write_en = 1'b0; bus1.iss_en = 1'b0; bus1.iss_address = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[k][i] = '0;
        m_pend[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Reset state, then preload r3 / issue r4 and reset mid-operation.
    apply(mk(0, 0, 0, 0,     0, 0, 3, 4));
    apply(mk(0, 1, 3, 'h5A,  1, 4, 3, 4));
    apply(mk(0, 0, 0, 0,     0, 0, 3, 4));
    apply(mk(1, 0, 0, 0,     0, 0, 3, 4));
    apply(mk(0, 0, 0, 0,     0, 0, 3, 4));
    // Write with same-cycle bypass, then hold.
    apply(mk(0, 1, 2, 'hA5,  0, 0, 2, 2));
    apply(mk(0, 0, 0, 0,     0, 0, 2, 2));
    // Zero register write and issue.
    apply(mk(0, 1, 0, 'hFF,  1, 0, 0, 0));
    apply(mk(0, 0, 0, 0,     0, 0, 0, 0));
    // Issue r5, retry ignored, writeback with bypass, drain.
    apply(mk(0, 0, 0, 0,     1, 5, 5, 5));
    apply(mk(0, 0, 0, 0,     1, 5, 5, 5));
    apply(mk(0, 1, 5, 'h33,  0, 5, 5, 5));
    apply(mk(0, 0, 0, 0,     0, 5, 5, 5));
    // Simultaneous writeback and re-issue of r6.
    apply(mk(0, 0, 0, 0,     1, 6, 6, 6));
    apply(mk(0, 1, 6, 'h77,  1, 6, 6, 6));
    apply(mk(0, 0, 0, 0,     0, 6, 6, 6));
    // Writeback to a non-pending register; error stays set.
    apply(mk(1, 0, 0, 0,     0, 0, 1, 1));
    apply(mk(0, 1, 1, 'h11,  0, 0, 1, 1));
    apply(mk(0, 0, 0, 0,     0, 0, 1, 1));
    apply(mk(0, 0, 0, 0,     0, 0, 1, 1));
    // Fill the scoreboard: r0..r7 (r0 ignored on instance 0).
    for (int r = 0; r < 8; r++) apply(mk(0, 0, 0, 0, 1, r, r, 7 - r));
    apply(mk(0, 0, 0, 0,     1, 3, 3, 7));
    apply(mk(0, 0, 0, 0,     0, 0, 0, 0));
    // Top register of the wide build.
    apply(mk(1, 0, 0, 0,     0, 0, 15, 15));
    apply(mk(0, 1, 15, 'hBEEF, 0, 0, 15, 15));
    apply(mk(0, 0, 0, 0,     0, 0, 15, 15));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      s.rst = ($urandom_range(0, 59) == 0);
      s.we  = 1'($urandom_range(0, 1));
      s.ie  = 1'($urandom_range(0, 1));
      s.a   = 4'($urandom_range(0, 15));
      s.b   = 4'($urandom_range(0, 15));
      s.d   = ($urandom_range(0, 3) == 0) ? s.a : 4'($urandom_range(0, 15));
      s.ia  = ($urandom_range(0, 3) == 0) ? s.d : 4'($urandom_range(0, 15));
      s.din = 16'($urandom);
      apply(s);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
